upg_mode_ctrl: RTL and testbench
================================

Name: upg_mode_ctrl

Overview:
- Sequences switching the CPU between normal execution and UART program-load mode.
- Debounces start_pg and holds the CPU core in reset while loading.
- Steers each uart_bmpg write to programrom or dmemory using address bit 14.
- Releases the CPU automatically after upg_done plus a hold window; no fpga_rst press is needed. Sits in cpu top between uart_bmpg_0 and the two memories.

Parameters:
- DEBOUNCE_CYCLES, 20, consecutive cycles start_pg must be high to register.
- RESUME_HOLD, 16, cycles cpu_rst_o stays high after the load completes.
- CNT_W, 15, width of the per-memory word counters.

Ports:
- fpga_clk  in  1  single clock for all logic.
- fpga_rst  in  1  reset, synchronous, active-high.
- start_pg  in  1  raw program-mode request button.
- upg_wen_i  in  1  UART write strobe; may stay high for several cycles.
- upg_adr_i  in  15  UART word address; bit 14 selects the target (0=rom, 1=ram).
- upg_dat_i  in  32  UART write data.
- upg_done_i  in  1  UART transfer complete, level.
- upg_rst_o  out  1  UART programmer reset: 1=held, 0=active.
- cpu_rst_o  out  1  CPU core reset to Ifetc32/Idecode32/io blocks.
- rom_wen_o  out  1  programrom write enable, one-cycle pulse.
- ram_wen_o  out  1  dmemory32 write enable, one-cycle pulse.
- wr_adr_o  out  14  registered write address, upg_adr_i[13:0].
- wr_dat_o  out  32  registered write data.
- rom_words_o  out  CNT_W  rom writes this session.
- ram_words_o  out  CNT_W  ram writes this session.
- busy_o  out  1  high in any state except RUN.
- err_o  out  1  sticky: write strobe seen outside LOAD.

Behaviour:
- Reset (fpga_rst=1 at a clock edge):
  - state=RUN; upg_rst_o=1; cpu_rst_o=1.
  - rom_wen_o=0, ram_wen_o=0; wr_adr_o=0; wr_dat_o=0.
  - Both counters=0; busy_o=0; err_o=0; debounce counter=0; sync flops=0.
  - First cycle after reset release in RUN: cpu_rst_o=0.
  - Reset mid-LOAD or mid-HOLD aborts immediately to RUN. Any pending write pulse is dropped.
- start_pg path:
  - 2-flop synchronizer, then a saturating counter that clears on any low sample.
  - start_seen is a one-cycle pulse on the cycle the counter reaches DEBOUNCE_CYCLES.
  - No further pulse until the synchronized input returns low.
  - Total latency from raw high to start_seen: DEBOUNCE_CYCLES+2 cycles.
- State RUN:
  - upg_rst_o=1, cpu_rst_o=0, busy_o=0.
  - start_seen -> LOAD. On the transition edge: counters clear, upg_rst_o=0, cpu_rst_o=1.
- State LOAD:
  - Edge-detect upg_wen_i; each 0->1 transition is exactly one write.
  - The write cycle after the edge: wr_adr_o/wr_dat_o latch the inputs sampled at the edge.
  - In that same cycle exactly one of rom_wen_o/ram_wen_o is high, per upg_adr_i[14]. Latency is 1 cycle.
  - The matching counter increments and saturates at all-ones.
  - upg_done_i=1 -> DRAIN. A write edge sampled in the same cycle is still issued.
  - start_seen in LOAD is ignored.
- State DRAIN:
  - One cycle. Lets the final write pulse complete; no new writes accepted.
  - Then -> HOLD with hold counter=0.
- State HOLD:
  - cpu_rst_o=1, upg_rst_o=0. Hold counter increments each cycle.
  - At RESUME_HOLD-1 -> RUN. Next cycle upg_rst_o=1 and cpu_rst_o=0.
  - Write edges here are ignored and set err_o.
- err_o: set by a upg_wen_i rising edge in RUN/DRAIN/HOLD; cleared only by fpga_rst.
- Counters hold their values in RUN so software and the display can read them after a load.
- All outputs are registered; there is no combinational input-to-output path.

Decomposition:
- Shared package upg_pkg:
  - State encoding: RUN=0, LOAD=1, DRAIN=2, HOLD=3 (2 bits).
  - Constant UPG_SEL_BIT=14.
  - Constant UPG_ADR_W=14.
- One sub-module, btn_debounce (synchronizer + counter + pulse), parameterised by DEBOUNCE_CYCLES. It is reused for the other push buttons.

Test Plan:
- Bounce: start_pg toggles high for 5 cycles then low, 3 times; then held high 30 cycles (DEBOUNCE_CYCLES=20) -> LOAD entered exactly 22 cycles after the final rise; busy_o=1, cpu_rst_o=1, upg_rst_o=0.
- Routing: in LOAD, wen pulses at adr 0x0003 dat 0xDEADBEEF, then adr 0x4005 dat 0x12345678 -> rom_wen_o pulse with wr_adr_o=3, then ram_wen_o pulse with wr_adr_o=5; rom_words_o=1, ram_words_o=1.
- Wide strobe: upg_wen_i held high 4 cycles -> exactly one write pulse, counter +1.
- Completion: last wen edge and upg_done_i in the same cycle -> final write issued; cpu_rst_o falls exactly 1+1+16 cycles later; upg_rst_o=1; counters retained.
- Abort and error: fpga_rst pulsed mid-LOAD -> next cycle state RUN, counters 0, cpu_rst_o=1 then 0. Later a wen edge in RUN -> err_o=1 and no write enable.

Source files
------------

// File: rtl/upg_pkg.sv
// Shared types and constants for the UART program-load controller.
package upg_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } upg_state_e;

  // Address bit 14 selects the target memory; the low 14 bits are the word address.
  localparam int UPG_SEL_BIT = 14;
  localparam int UPG_ADR_W   = 14;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, saturating stability counter,
// and a single pulse once the button has been steadily high long enough.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    // NOTE: every branch assigns cnt_d, so no latch is inferred.
    if (!sync2_q)
      cnt_d = '0;
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;
  end

  // Fires only on the step into saturation, so a held button gives one pulse.
  assign pulse_o = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/upg_mode_ctrl.sv
// Switches the CPU between normal run and UART program load, steering each
// UART word to programrom or dmemory and releasing the core after a hold window.
module upg_mode_ctrl
  import upg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int RESUME_HOLD     = 16,
  parameter int CNT_W           = 15
) (
  input  logic                 fpga_clk,
  input  logic                 fpga_rst,
  input  logic                 start_pg,
  input  logic                 upg_wen_i,
  input  logic [UPG_ADR_W:0]   upg_adr_i,
  input  logic [31:0]          upg_dat_i,
  input  logic                 upg_done_i,
  output logic                 upg_rst_o,
  output logic                 cpu_rst_o,
  output logic                 rom_wen_o,
  output logic                 ram_wen_o,
  output logic [UPG_ADR_W-1:0] wr_adr_o,
  output logic [31:0]          wr_dat_o,
  output logic [CNT_W-1:0]     rom_words_o,
  output logic [CNT_W-1:0]     ram_words_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int HOLD_W = (RESUME_HOLD > 1) ? $clog2(RESUME_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESUME_HOLD - 1);

  upg_state_e           state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                 wen_prev_q;
  logic                 rom_wen_q, rom_wen_d;
  logic                 ram_wen_q, ram_wen_d;
  logic [UPG_ADR_W-1:0] wr_adr_q, wr_adr_d;
  logic [31:0]          wr_dat_q, wr_dat_d;
  logic [CNT_W-1:0]     rom_cnt_q, rom_cnt_d;
  logic [CNT_W-1:0]     ram_cnt_q, ram_cnt_d;
  logic                 upg_rst_q, upg_rst_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 start_seen;
  logic                 wen_rise;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_db (
    .clk    (fpga_clk),
    .rst    (fpga_rst),
    .btn_i  (start_pg),
    .pulse_o(start_seen)
  );

  // The UART strobe can last several cycles; only its leading edge is a write.
  assign wen_rise = upg_wen_i & ~wen_prev_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rom_wen_d  = 1'b0;
    ram_wen_d  = 1'b0;
    wr_adr_d   = wr_adr_q;
    wr_dat_d   = wr_dat_q;
    rom_cnt_d  = rom_cnt_q;
    ram_cnt_d  = ram_cnt_q;
    err_d      = err_q;

    case (state_q)
      ST_RUN: begin
        if (start_seen) begin
          state_d   = ST_LOAD;
          rom_cnt_d = '0;
          ram_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (wen_rise) begin
          wr_adr_d = upg_adr_i[UPG_ADR_W-1:0];
          wr_dat_d = upg_dat_i;
          if (upg_adr_i[UPG_SEL_BIT]) begin
            ram_wen_d = 1'b1;
            if (ram_cnt_q != '1) ram_cnt_d = ram_cnt_q + 1'b1;
          end else begin
            rom_wen_d = 1'b1;
            if (rom_cnt_q != '1) rom_cnt_d = rom_cnt_q + 1'b1;
          end
        end
        if (upg_done_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST)
          state_d = ST_RUN;
        else
          hold_cnt_d = hold_cnt_q + 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    if (wen_rise && (state_q != ST_LOAD)) err_d = 1'b1;

    // Reset outputs follow the next state so they change on the transition edge.
    upg_rst_d = (state_d == ST_RUN);
    cpu_rst_d = (state_d != ST_RUN);
    busy_d    = (state_d != ST_RUN);
  end

  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      state_q    <= ST_RUN;
      hold_cnt_q <= '0;
      wen_prev_q <= 1'b0;
      rom_wen_q  <= 1'b0;
      ram_wen_q  <= 1'b0;
      wr_adr_q   <= '0;
      wr_dat_q   <= '0;
      rom_cnt_q  <= '0;
      ram_cnt_q  <= '0;
      upg_rst_q  <= 1'b1;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      wen_prev_q <= upg_wen_i;
      rom_wen_q  <= rom_wen_d;
      ram_wen_q  <= ram_wen_d;
      wr_adr_q   <= wr_adr_d;
      wr_dat_q   <= wr_dat_d;
      rom_cnt_q  <= rom_cnt_d;
      ram_cnt_q  <= ram_cnt_d;
      upg_rst_q  <= upg_rst_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign upg_rst_o   = upg_rst_q;
  assign cpu_rst_o   = cpu_rst_q;
  assign rom_wen_o   = rom_wen_q;
  assign ram_wen_o   = ram_wen_q;
  assign wr_adr_o    = wr_adr_q;
  assign wr_dat_o    = wr_dat_q;
  assign rom_words_o = rom_cnt_q;
  assign ram_words_o = ram_cnt_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_upg_mode_ctrl.sv
// Directed bench for upg_mode_ctrl: expected memory writes go into a queue as
// stimulus is driven and are matched against the writes the DUT emits.
module tb_upg_mode_ctrl;

  typedef struct packed {
    logic        rom;
    logic        ram;
    logic [13:0] adr;
    logic [31:0] dat;
  } wr_t;

  logic        clk = 1'b0;
  logic        fpga_rst;
  logic        start_pg;
  logic        upg_wen_i;
  logic [14:0] upg_adr_i;
  logic [31:0] upg_dat_i;
  logic        upg_done_i;
  logic        upg_rst_o;
  logic        cpu_rst_o;
  logic        rom_wen_o;
  logic        ram_wen_o;
  logic [13:0] wr_adr_o;
  logic [31:0] wr_dat_o;
  logic [14:0] rom_words_o;
  logic [14:0] ram_words_o;
  logic        busy_o;
  logic        err_o;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];

  upg_mode_ctrl #(
    .DEBOUNCE_CYCLES(20),
    .RESUME_HOLD    (16),
    .CNT_W          (15)
  ) dut (
    .fpga_clk   (clk),
    .fpga_rst   (fpga_rst),
    .start_pg   (start_pg),
    .upg_wen_i  (upg_wen_i),
    .upg_adr_i  (upg_adr_i),
    .upg_dat_i  (upg_dat_i),
    .upg_done_i (upg_done_i),
    .upg_rst_o  (upg_rst_o),
    .cpu_rst_o  (cpu_rst_o),
    .rom_wen_o  (rom_wen_o),
    .ram_wen_o  (ram_wen_o),
    .wr_adr_o   (wr_adr_o),
    .wr_dat_o   (wr_dat_o),
    .rom_words_o(rom_words_o),
    .ram_words_o(ram_words_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // Record every write the DUT issues, sampled mid-cycle.
  always @(negedge clk) begin
    if (rom_wen_o || ram_wen_o)
      obs_q.push_back(wr_t'({rom_wen_o, ram_wen_o, wr_adr_o, wr_dat_o}));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [14:0] adr, input logic [31:0] dat,
                          input int width, input bit expect_wr);
    upg_adr_i = adr;
    upg_dat_i = dat;
    upg_wen_i = 1'b1;
    if (expect_wr)
      exp_q.push_back(wr_t'{rom: ~adr[14], ram: adr[14], adr: adr[13:0], dat: dat});
    step(width);
    upg_wen_i = 1'b0;
    step(2);
  endtask

  task automatic sb_check(input string name);
    int n;
    wr_t e;
    wr_t o;
    check({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({name, "_write"}, 64'(o), 64'(e));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    fpga_rst   = 1'b1;
    start_pg   = 1'b0;
    upg_wen_i  = 1'b0;
    upg_adr_i  = '0;
    upg_dat_i  = '0;
    upg_done_i = 1'b0;
    step(2);

    check("rst_busy",    busy_o,      0);
    check("rst_upg_rst", upg_rst_o,   1);
    check("rst_cpu_rst", cpu_rst_o,   1);
    check("rst_wen",     {rom_wen_o, ram_wen_o}, 0);
    check("rst_adr",     wr_adr_o,    0);
    check("rst_dat",     wr_dat_o,    0);
    check("rst_words",   {rom_words_o, ram_words_o}, 0);
    check("rst_err",     err_o,       0);

    fpga_rst = 1'b0;
    step(1);
    check("run_cpu_rst", cpu_rst_o, 0);
    check("run_upg_rst", upg_rst_o, 1);

    // Bouncing button: three short highs must not start a load.
    for (int i = 0; i < 3; i++) begin
      start_pg = 1'b1;
      step(5);
      start_pg = 1'b0;
      step(5);
    end
    check("bounce_busy", busy_o, 0);

    start_pg = 1'b1;
    step(21);
    check("db_early_busy", busy_o, 0);
    step(1);
    check("db_load_busy",    busy_o,    1);
    check("db_load_cpu_rst", cpu_rst_o, 1);
    check("db_load_upg_rst", upg_rst_o, 0);
    step(8);
    start_pg = 1'b0;

    // Routing: rom write with explicit latency checks, then a ram write.
    upg_adr_i = 15'h0003;
    upg_dat_i = 32'hDEADBEEF;
    upg_wen_i = 1'b1;
    exp_q.push_back(wr_t'{rom: 1'b1, ram: 1'b0, adr: 14'h0003, dat: 32'hDEADBEEF});
    step(1);
    check("rom_pulse",   {rom_wen_o, ram_wen_o}, 2'b10);
    check("rom_adr",     wr_adr_o, 14'h0003);
    check("rom_dat",     wr_dat_o, 32'hDEADBEEF);
    upg_wen_i = 1'b0;
    step(1);
    check("rom_pulse_end", rom_wen_o, 0);
    step(1);
    do_write(15'h4005, 32'h12345678, 1, 1'b1);
    check("route_rom_words", rom_words_o, 1);
    check("route_ram_words", ram_words_o, 1);
    sb_check("route");

    // Wide strobe is one write.
    do_write(15'h0010, 32'hA5A50001, 4, 1'b1);
    check("wide_rom_words", rom_words_o, 2);
    check("wide_ram_words", ram_words_o, 1);
    sb_check("wide");

    // Final write coincides with upg_done_i.
    upg_adr_i  = 15'h4007;
    upg_dat_i  = 32'hCAFEF00D;
    upg_wen_i  = 1'b1;
    upg_done_i = 1'b1;
    exp_q.push_back(wr_t'{rom: 1'b0, ram: 1'b1, adr: 14'h0007, dat: 32'hCAFEF00D});
    step(1);
    check("done_ram_pulse", ram_wen_o, 1);
    check("done_cpu_rst",   cpu_rst_o, 1);
    upg_wen_i  = 1'b0;
    upg_done_i = 1'b0;
    step(16);
    check("hold_last_cpu_rst", cpu_rst_o, 1);
    check("hold_last_busy",    busy_o,    1);
    step(1);
    check("resume_cpu_rst",   cpu_rst_o,   0);
    check("resume_upg_rst",   upg_rst_o,   1);
    check("resume_busy",      busy_o,      0);
    check("resume_rom_words", rom_words_o, 2);
    check("resume_ram_words", ram_words_o, 2);
    check("resume_err",       err_o,       0);
    sb_check("done");

    // New session clears the counters; then abort it with fpga_rst.
    start_pg = 1'b1;
    step(22);
    check("reload_busy", busy_o, 1);
    start_pg = 1'b0;
    do_write(15'h0001, 32'h11112222, 1, 1'b1);
    check("reload_rom_words", rom_words_o, 1);
    check("reload_ram_words", ram_words_o, 0);
    sb_check("reload");

    upg_adr_i = 15'h4009;
    upg_dat_i = 32'h33334444;
    upg_wen_i = 1'b1;
    fpga_rst  = 1'b1;
    step(1);
    check("abort_busy",    busy_o,    0);
    check("abort_words",   {rom_words_o, ram_words_o}, 0);
    check("abort_cpu_rst", cpu_rst_o, 1);
    check("abort_upg_rst", upg_rst_o, 1);
    check("abort_wen",     {rom_wen_o, ram_wen_o}, 0);
    fpga_rst  = 1'b0;
    upg_wen_i = 1'b0;
    step(1);
    check("abort_run_cpu_rst", cpu_rst_o, 0);
    check("abort_err",         err_o,     0);
    step(2);
    sb_check("abort");

    // A strobe edge in RUN flags an error and writes nothing.
    do_write(15'h0002, 32'hBAD0BAD0, 1, 1'b0);
    check("err_set",       err_o,       1);
    check("err_rom_words", rom_words_o, 0);
    sb_check("err");
    step(5);
    check("err_sticky", err_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
